// File: rtl/classifier_sample_deserializer.sv
// classifier_sample_deserializer
// Collects N_SAMPLES serial samples (val/rdy) into a frame buffer and
// presents the full frame as an unpacked array on a val/rdy send port.
// Element 0 of the frame is the first sample received.

// One frame-buffer entry: cleared by reset, loaded when its index is written.
module classifier_sample_lane #(
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we_i,
    input  logic [BIT_WIDTH-1:0] d_i,
    output logic [BIT_WIDTH-1:0] q_o
);
    logic [BIT_WIDTH-1:0] data_q;

    // Hold the sample; only the lane selected by the write index loads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) data_q <= '0;
        else if (we_i) data_q <= d_i;
    end

    assign q_o = data_q;
endmodule

module classifier_sample_deserializer #(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    input  logic [BIT_WIDTH-1:0] recv_msg,
    output logic                 send_val,
    input  logic                 send_rdy,
    output logic [BIT_WIDTH-1:0] send_msg [N_SAMPLES-1:0]
);
    localparam int IDX_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    // Explicit last-index compare so non-power-of-two frame sizes wrap correctly.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

    typedef enum logic {
        FILL = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   wr_en;
    logic [N_SAMPLES-1:0]   lane_we;

    // Handshake flags depend only on state; reset forces both low so no
    // transfer can complete while reset is high.
    assign recv_rdy = (state_q == FILL) && !reset;
    assign send_val = (state_q == SEND) && !reset;
    assign wr_en    = recv_val && recv_rdy;

    // State and write index registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: advance the index per accepted sample, flip to SEND on the
    // last one, and return to FILL once the frame is taken.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            FILL: begin
                if (wr_en) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = SEND;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            SEND: begin
                if (send_val && send_rdy) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    // Frame buffer lanes drive send_msg directly in every state.
    genvar i;
    generate
        for (i = 0; i < N_SAMPLES; i++) begin : g_lane
            assign lane_we[i] = wr_en && (idx_q == IDX_W'(i));
            classifier_sample_lane #(.BIT_WIDTH(BIT_WIDTH)) u_lane (
                .clk   (clk),
                .reset (reset),
                .we_i  (lane_we[i]),
                .d_i   (recv_msg),
                .q_o   (send_msg[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_classifier_sample_deserializer.sv
// Bench for classifier_sample_deserializer: two instances (N=8, N=5), each
// driven by directed plus random stimulus and checked every cycle against a
// queue-based frame model.
module tb_classifier_sample_deserializer;
    logic clk = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_cfg
            localparam int N = (g == 0) ? 8 : 5;

            logic        rst = 1'b1;
            logic        rv = 1'b0;
            logic        sr = 1'b0;
            logic [31:0] msg = '0;
            logic        rr, sv;
            logic [31:0] smsg [N-1:0];
            bit          done_b = 1'b0;

            // model state
            logic [31:0] pend [$];
            logic [31:0] frame [N];
            bit          have = 1'b0;
            int          nsent = 0;
            int          obs_hs = 0;

            classifier_sample_deserializer #(.BIT_WIDTH(32), .N_SAMPLES(N)) dut (
                .clk      (clk),
                .reset    (rst),
                .recv_val (rv),
                .recv_rdy (rr),
                .recv_msg (msg),
                .send_val (sv),
                .send_rdy (sr),
                .send_msg (smsg)
            );

            // Model: collect accepted samples in a queue; a full queue becomes
            // the pending frame, which blocks input until it is taken.
            initial forever begin
                @(posedge clk or posedge rst);
                if (rst) begin
                    pend.delete();
                    have = 1'b0;
                end else if (have) begin
                    if (sr) begin
                        have = 1'b0;
                        nsent++;
                    end
                end else if (rv) begin
                    pend.push_back(msg);
                    if (pend.size() == N) begin
                        for (int i = 0; i < N; i++) frame[i] = pend[i];
                        pend.delete();
                        have = 1'b1;
                    end
                end
            end

            // Compare on every falling edge.
            initial forever begin
                @(negedge clk);
                chk("recv_rdy", {31'b0, rr}, {31'b0, !rst && !have});
                chk("send_val", {31'b0, sv}, {31'b0, !rst && have});
                if (rst) begin
                    for (int i = 0; i < N; i++) chk("send_msg_rst", smsg[i], 32'h0);
                end else if (have) begin
                    for (int i = 0; i < N; i++) chk("send_msg", smsg[i], frame[i]);
                end
                if (sv && sr && !rst) obs_hs++;
            end

            initial begin
                int cnt;
                step();
                step();
                chk("rst_rr", {31'b0, rr}, 32'h0);
                chk("rst_sv", {31'b0, sv}, 32'h0);
                rst = 1'b0;

                // basic frame, back-to-back, send_rdy high
                sr = 1'b1;
                for (int k = 1; k <= N; k++) begin
                    rv = 1'b1;
                    msg = 32'(k) << 16;
                    step();
                end
                rv = 1'b0;
                chk("basic_sv", {31'b0, sv}, 32'h1);
                chk("basic_rr", {31'b0, rr}, 32'h0);
                chk("basic_m0", smsg[0], 32'h0001_0000);
                chk("basic_mlast", smsg[N-1], 32'(N) << 16);
                step();
                chk("basic_sv_after", {31'b0, sv}, 32'h0);
                chk("basic_rr_after", {31'b0, rr}, 32'h1);

                // back-pressure
                sr = 1'b0;
                rv = 1'b1;
                for (int k = 1; k <= N; k++) begin
                    msg = 32'd100 + 32'(k);
                    step();
                end
                for (int j = 0; j < 5; j++) begin
                    msg = 32'd200 + 32'(j);
                    chk("bp_sv", {31'b0, sv}, 32'h1);
                    chk("bp_m0", smsg[0], 32'd101);
                    step();
                end
                sr = 1'b1;
                msg = 32'd300;
                step();
                for (int k = 0; k < N; k++) begin
                    msg = 32'd300 + 32'(k);
                    step();
                end
                rv = 1'b0;
                chk("bp_next_m0", smsg[0], 32'd300);
                step();

                // bubbles
                sr = 1'b0;
                for (int i = 0; i < 2 * N; i++) begin
                    rv = (i % 2 == 0);
                    msg = 32'd10 + 32'(i / 2);
                    step();
                    if (i == 2 * N - 2) chk("bub_sv", {31'b0, sv}, 32'h1);
                end
                chk("bub_mlast", smsg[N-1], 32'd10 + 32'(N - 1));
                sr = 1'b1;
                rv = 1'b0;
                step();

                // back-to-back frames
                cnt = 0;
                rv = 1'b1;
                for (int c = 0; c < 3 * (N + 1); c++) begin
                    msg = $urandom;
                    step();
                    if (sv) cnt++;
                end
                rv = 1'b0;
                chk("b2b_frames", 32'(cnt), 32'd3);

                // random traffic
                for (int c = 0; c < 400; c++) begin
                    rv = ($urandom_range(0, 3) != 0);
                    sr = ($urandom_range(0, 2) != 0);
                    msg = $urandom;
                    step();
                end
                rv = 1'b0;

                // reset asserted between edges, then mid-fill
                #2 rst = 1'b1;
                #1;
                chk("arst_rr", {31'b0, rr}, 32'h0);
                chk("arst_sv", {31'b0, sv}, 32'h0);
                step();
                rst = 1'b0;
                rv = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    msg = 32'd50 + 32'(k);
                    step();
                end
                #2 rst = 1'b1;
                #1;
                chk("fill_rst_rr", {31'b0, rr}, 32'h0);
                for (int i = 0; i < N; i++) chk("fill_rst_msg", smsg[i], 32'h0);
                step();
                rst = 1'b0;
                sr = 1'b0;
                for (int k = 0; k < N; k++) begin
                    msg = 32'd20 + 32'(k);
                    step();
                end
                rv = 1'b0;
                chk("post_rst_sv", {31'b0, sv}, 32'h1);
                chk("post_rst_m0", smsg[0], 32'd20);
                chk("post_rst_mlast", smsg[N-1], 32'd20 + 32'(N - 1));

                // reset while in SEND with send_rdy high
                step();
                sr = 1'b1;
                #2 rst = 1'b1;
                #1;
                chk("send_rst_sv", {31'b0, sv}, 32'h0);
                step();
                rst = 1'b0;
                step();
                chk("send_rst_rr", {31'b0, rr}, 32'h1);
                chk("send_rst_sv2", {31'b0, sv}, 32'h0);
                rv = 1'b1;
                for (int k = 0; k < N; k++) begin
                    msg = 32'hA0 + 32'(k);
                    step();
                end
                rv = 1'b0;
                chk("final_m0", smsg[0], 32'hA0);
                step();
                step();
                chk("handshakes", 32'(obs_hs), 32'(nsent));
                done_b = 1'b1;
            end
        end
    endgenerate

    initial begin
        int c;
        c = 0;
        while (c < 20000 && !(g_cfg[0].done_b && g_cfg[1].done_b)) begin
            @(posedge clk);
            c++;
        end
        checks++;
        if (!(g_cfg[0].done_b && g_cfg[1].done_b)) begin
            errors++;
            $display("FAIL timeout actual=%0d cycles required=completion", c);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
